if_id_pipe_reg: RTL

- Parametrised IF→ID pipeline boundary with a valid/ready handshake, flush, and a fetch-exception tag.
- Optional 2-entry skid buffer that keeps in_ready off the combinational path.
- Sits between the fetch unit (inst memory + PC+4) and the decoder.
- Presents MIPS-I field slices of the held instruction to ID, plus a saturating stall counter for perf monitoring.

---
 rtl/if_id_pipe_reg.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF->ID pipeline register with valid/ready, flush, fault tag and stall counter.
// Optional 2-entry skid buffer (registered in_ready) enabled by defining SKID_EN.
module if_id_pipe_reg #(
   parameter int                INST_W   = 32,
   parameter int                PC_W     = 32,
   parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000,
   parameter int                CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [INST_W-1:0] in_inst,
   input  logic [PC_W-1:0]   in_pc4,
   input  logic              in_exc,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [PC_W-1:0]   out_pc4,
   output logic              out_exc,
   output logic [5:0]        op,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        func,
   output logic [15:0]       imm,
   output logic [25:0]       adr,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              main_valid;
   logic [INST_W-1:0] main_inst;
   logic [PC_W-1:0]   main_pc4;
   logic              main_exc;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = main_valid & out_ready;

`ifdef SKID_EN
   logic              skid_valid;
   logic [INST_W-1:0] skid_inst;
   logic [PC_W-1:0]   skid_pc4;
   logic              skid_exc;
   logic              in_ready_q;

   // in_ready_q always tracks ~skid_valid, so it never depends on out_ready.
   assign in_ready = in_ready_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid <= 1'b0;
         main_inst  <= NOP_INST;
         main_pc4   <= '0;
         main_exc   <= 1'b0;
         skid_valid <= 1'b0;
         skid_inst  <= NOP_INST;
         skid_pc4   <= '0;
         skid_exc   <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (out_xfer || !main_valid) begin
         if (skid_valid) begin
            main_valid <= 1'b1;
            main_inst  <= skid_inst;
            main_pc4   <= skid_pc4;
            main_exc   <= skid_exc;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
         end else if (in_xfer) begin
            main_valid <= 1'b1;
            main_inst  <= in_inst;
            main_pc4   <= in_pc4;
            main_exc   <= in_exc;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         skid_valid <= 1'b1;
         skid_inst  <= in_inst;
         skid_pc4   <= in_pc4;
         skid_exc   <= in_exc;
         in_ready_q <= 1'b0;
      end
   end
`else
   assign in_ready = ~main_valid | out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid <= 1'b0;
         main_inst  <= NOP_INST;
         main_pc4   <= '0;
         main_exc   <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
      end else if (in_xfer) begin
         main_valid <= 1'b1;
         main_inst  <= in_inst;
         main_pc4   <= in_pc4;
         main_exc   <= in_exc;
      end else if (out_xfer) begin
         main_valid <= 1'b0;
      end
   end
`endif

   // Saturating; flush deliberately leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign out_valid = main_valid;
   assign out_inst  = main_valid ? main_inst : NOP_INST;
   assign out_pc4   = main_pc4;
   assign out_exc   = main_valid & main_exc;

   assign op    = out_inst[31:26];
   assign rs    = out_inst[25:21];
   assign rt    = out_inst[20:16];
   assign rd    = out_inst[15:11];
   assign shamt = out_inst[10:6];
   assign func  = out_inst[5:0];
   assign imm   = out_inst[15:0];
   assign adr   = out_inst[25:0];

endmodule
